// File: rtl/gray_to_binary_serial.sv
// Serial decoder for the LSB-anchored gray code: one result bit per clock, LSB first,
// with a valid/ready handshake on both the input word and the decoded output word.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for a word; in_ready = 1
// CONVERT | resolving one result bit per cycle at bit_idx; busy = 1
// DONE    | binary_out holds the result; out_valid = 1 until out_ready
module gray_to_binary_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] gray_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] binary_out,
    output logic             busy
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_nxt;
    logic [IDX_W-1:0] bit_idx;
    logic             prev_bit;
    logic             bit_now;
    logic             accept;
    logic             last_bit;

    assign accept   = (state == IDLE) && in_valid;
    assign last_bit = (state == CONVERT) && (bit_idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = CONVERT;
                end
            end
            CONVERT: begin
                if (bit_idx == LAST_IDX) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            CONVERT: busy      = 1'b1;
            DONE:    out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // prev_bit starts at 0 so bit 0 resolves to the captured gray bit itself.
    always_comb begin
        bit_now          = gray_q[bit_idx] ^ prev_bit;
        res_nxt          = res_q;
        res_nxt[bit_idx] = bit_now;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gray_q     <= '0;
            res_q      <= '0;
            bit_idx    <= '0;
            prev_bit   <= 1'b0;
            binary_out <= '0;
        end else if (accept) begin
            gray_q   <= gray_in;
            res_q    <= '0;
            bit_idx  <= '0;
            prev_bit <= 1'b0;
        end else if (state == CONVERT) begin
            res_q    <= res_nxt;
            prev_bit <= bit_now;
            if (last_bit) begin
                binary_out <= res_nxt;
            end else begin
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gray_to_binary_serial.sv
// Bench for gray_to_binary_serial: countdown-based reference model checked every cycle,
// plus directed corner words, backpressure, mid-conversion reset and an exhaustive round trip.
module tb_gray_to_binary_serial;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] gray_in = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] binary_out;
    logic         busy;

    int errors = 0;
    int checks = 0;

    gray_to_binary_serial #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .gray_in    (gray_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .binary_out (binary_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Each result bit is the XOR of all gray bits at or below it: prefix XOR via shifts.
    function automatic logic [W-1:0] ref_decode(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = '0;
        for (int k = 0; k < W; k++) b = b ^ (g << k);
        return b;
    endfunction

    function automatic logic [W-1:0] ref_encode(input logic [W-1:0] b);
        return b ^ (b << 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Reference model: idle / cycles-left countdown / result-held
    logic         m_idle = 1'b1;
    int           m_left = 0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_word = '0;
    logic [W-1:0] m_out  = '0;
    logic         chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_idle = 1'b1;
            m_left = 0;
            m_done = 1'b0;
            m_out  = '0;
        end else if (m_idle && in_valid) begin
            m_idle = 1'b0;
            m_word = ref_decode(gray_in);
            m_left = W;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_done = 1'b1;
                m_out  = m_word;
            end
        end else if (m_done && out_ready) begin
            m_done = 1'b0;
            m_idle = 1'b1;
        end
    end

    logic [W-1:0] exp_q[$];
    logic         sb_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready",   in_ready,   m_idle);
            check("busy",       busy,       m_left > 0);
            check("out_valid",  out_valid,  m_done);
            check("binary_out", binary_out, m_out);
            if (sb_en && out_valid && out_ready) begin
                if (exp_q.size() == 0) timeout_fail("scoreboard_extra");
                else check("roundtrip", binary_out, exp_q.pop_front());
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) timeout_fail("wait_in_ready");
    endtask

    // Send one word; hold = cycles of out_ready=0 after out_valid; noise = junk on inputs while converting.
    task automatic send(input logic [W-1:0] g, input int hold, input bit noise,
                        input logic [W-1:0] exp_val);
        int n;
        wait_ready();
        gray_in   = g;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = noise;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            if (noise) gray_in = W'($urandom);
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        if (n >= 40) timeout_fail("wait_out_valid");
        check("latency", n, W);
        check("decode", binary_out, exp_val);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1'b1);
            check("hold_data",  binary_out, exp_val);
            check("hold_busy_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("consumed_valid", out_valid, 1'b0);
        check("back_idle", in_ready, 1'b1);
    endtask

    task automatic reset_mid(input logic [W-1:0] g);
        wait_ready();
        gray_in  = g;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst      = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rst_out_valid",  out_valid,  1'b0);
        check("rst_busy",       busy,       1'b0);
        check("rst_binary_out", binary_out, '0);
        check("rst_in_ready",   in_ready,   1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [W-1:0] g;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        rst    = 1'b0;
        check("reset_in_ready",   in_ready,   1'b1);
        check("reset_out_valid",  out_valid,  1'b0);
        check("reset_busy",       busy,       1'b0);
        check("reset_binary_out", binary_out, '0);

        send(8'h0F, 0, 0, 8'h05);
        send(8'h01, 0, 0, 8'hFF);
        send(8'h80, 0, 0, 8'h80);
        send(8'h00, 0, 0, 8'h00);
        send(8'hFF, 0, 0, 8'h55);
        send(8'h0F, 5, 0, 8'h05);
        send(8'h01, 0, 1, 8'hFF);
        reset_mid(8'hA5);
        check("post_reset_idle", in_ready, 1'b1);
        send(8'h0F, 0, 0, 8'h05);

        for (int i = 0; i < 30; i++) begin
            g = W'($urandom);
            if ($urandom_range(0, 6) == 0) reset_mid(g);
            send(g, $urandom_range(0, 3), 1'($urandom_range(0, 1)), ref_decode(g));
        end

        // Exhaustive round trip, in_valid held high so words go back-to-back.
        sb_en     = 1'b1;
        out_ready = 1'b1;
        for (int v = 0; v < 256; v++) begin
            gray_in = ref_encode(W'(v));
            exp_q.push_back(W'(v));
            in_valid = 1'b1;
            wait_ready();
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) timeout_fail("roundtrip_drain");
        repeat (3) @(posedge clk);
        #1;
        sb_en     = 1'b0;
        out_ready = 1'b0;
        check("roundtrip_left", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gray_to_binary_serial.md
GRAY_TO_BINARY_SERIAL -- requirements
Module: gray_to_binary_serial

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, giving the code word width in bits; legal range 2..32.
REQ-002 SHALL provide clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL provide rst  input  1  synchronous, active-high reset.
REQ-004 SHALL provide in_valid  input  1  gray_in holds a word to decode.
REQ-005 SHALL provide in_ready  output  1  the block can accept a word this cycle.
REQ-006 SHALL provide gray_in  input  WIDTH  the gray-coded word.
REQ-007 SHALL provide out_valid  output  1  binary_out holds a decoded word.
REQ-008 SHALL provide out_ready  input  1  the consumer accepts binary_out this cycle.
REQ-009 SHALL provide binary_out  output  WIDTH  the decoded binary word.
REQ-010 SHALL provide busy  output  1  a conversion is in progress (state CONVERT).

Function
REQ-011 SHALL decode the team's LSB-anchored gray code: bin[0] = gray[0]; bin[i] = gray[i] XOR bin[i-1] for i = 1..WIDTH-1.
REQ-012 SHALL implement three states: IDLE, CONVERT and DONE.
REQ-013 SHALL drive in_ready = 1 only in IDLE, and 0 in CONVERT and DONE.
REQ-014 SHALL accept a word on a rising edge where in_valid && in_ready, capture gray_in into an internal register, clear the bit index to 0, and move to CONVERT.
REQ-015 SHALL ignore gray_in changes after capture.
REQ-016 SHALL, in CONVERT, resolve exactly one result bit per cycle, LSB first, at the current bit index; each bit uses the captured gray bit and the previously resolved bit.
REQ-017 SHALL, on the edge that resolves bit WIDTH-1, move to DONE and assert out_valid, so out_valid rises exactly WIDTH cycles after the acceptance edge.
REQ-018 SHALL, in DONE, hold out_valid = 1 and binary_out stable until an edge where out_ready = 1.
REQ-019 SHALL, on that edge, deassert out_valid and return to IDLE.
REQ-020 SHALL NOT accept a new word in the same cycle the result is consumed; minimum spacing between accepted words is WIDTH+2 cycles.
REQ-021 SHALL ignore out_ready outside DONE, and ignore in_valid outside IDLE.
REQ-022 SHALL hold binary_out at its last decoded value while in IDLE and CONVERT, and update it only on entry to DONE.
REQ-023 SHALL drive busy = 1 exactly while in CONVERT.
REQ-024 SHALL keep the bit index WIDTH-bounded, with no wrap past WIDTH-1.

Reset
REQ-025 SHALL, when rst = 1 on a rising edge, force state IDLE, out_valid = 0, busy = 0, binary_out = 0, bit index = 0 and captured word = 0; in_ready becomes 1 in the following cycle.
REQ-026 SHALL give rst priority over all handshakes; asserting it during CONVERT or DONE aborts the word and produces no output.
REQ-027 SHALL NOT accept a word on any edge where rst = 1, even if in_valid = 1.

Verification
REQ-028 SHALL verify basic decode: WIDTH=8, gray_in=8'h0F accepted, out_ready=1 -> out_valid rises 8 cycles after acceptance with binary_out=8'h05, and in_ready returns 1 the next cycle.
REQ-029 SHALL verify corner words: gray_in=8'h01 -> 8'hFF; gray_in=8'h80 -> 8'h80; gray_in=8'h00 -> 8'h00; gray_in=8'hFF -> 8'h55.
REQ-030 SHALL verify backpressure: out_ready held 0 for 5 cycles after out_valid -> out_valid and binary_out held stable and in_ready=0 throughout; release -> one-cycle handshake, then IDLE.
REQ-031 SHALL verify input ignored while busy: gray_in toggled and in_valid=1 during CONVERT -> result reflects only the captured word, and no second word is accepted.
REQ-032 SHALL verify reset mid-operation: rst pulsed at CONVERT cycle 4 -> out_valid never asserts, all outputs reset per REQ-025, and the next word decodes correctly.
REQ-033 SHALL verify exhaustive round-trip: all 256 binary values encoded per REQ-011 and fed back-to-back -> every binary_out equals the original value.
